// File: rtl/aespim_mixcol_engine.sv
// Sequential AES MixColumns / InvMixColumns engine: accepts a 128-bit state,
// transforms COLS_PER_CYCLE columns per clock and returns the result via valid/ready.
module aespim_mixcol_engine #(
  parameter int unsigned COLS_PER_CYCLE = 1,
  parameter int unsigned NUM_COLS       = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic                      in_inv_i,
  input  logic [32*NUM_COLS-1:0]    in_state_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [32*NUM_COLS-1:0]    out_state_o,
  output logic                      busy_o
);

  localparam int unsigned STATE_W = 32 * NUM_COLS;
  localparam int unsigned GROUPS  = NUM_COLS / COLS_PER_CYCLE;
  localparam int unsigned CNT_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int unsigned GRP_W   = 32 * COLS_PER_CYCLE;

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4) || NUM_COLS != 4) begin : g_param_check
    $error("aespim_mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4 and NUM_COLS must be 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [STATE_W-1:0]   data_q, data_d;
  logic                 inv_q, inv_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic [GRP_W-1:0]     grp_in, grp_out;
  logic                 last_grp;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // One column; both directions share the xtime chain (x2, x4, x8 per byte).
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[8*r +: 8];
      x2[r] = xtime(a[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
    end
    for (int r = 0; r < 4; r++) begin
      if (!inv) begin
        res[8*r +: 8] = x2[r] ^ x2[(r+1)%4] ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
      end else begin
        res[8*r +: 8] = (x8[r] ^ x4[r] ^ x2[r])
                      ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                      ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                      ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
      end
    end
    return res;
  endfunction

  // Select the active column group and transform it.
  always_comb begin
    grp_in  = '0;
    grp_out = '0;
    for (int g = 0; g < int'(GROUPS); g++) begin
      if (cnt_q == CNT_W'(g)) grp_in = data_q[g*GRP_W +: GRP_W];
    end
    for (int k = 0; k < int'(COLS_PER_CYCLE); k++) begin
      grp_out[32*k +: 32] = mix_col(grp_in[32*k +: 32], inv_q);
    end
  end

  assign last_grp = (cnt_q == CNT_W'(GROUPS - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      data_q      <= '0;
      inv_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      inv_q       <= inv_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and datapath update; clear overrides every transition.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    inv_d   = inv_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = BUSY;
          data_d  = in_state_i;
          inv_d   = in_inv_i;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        for (int g = 0; g < int'(GROUPS); g++) begin
          if (cnt_q == CNT_W'(g)) data_d[g*GRP_W +: GRP_W] = grp_out;
        end
        if (last_grp) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d = IDLE;
      data_d  = '0;
      inv_d   = 1'b0;
      cnt_d   = '0;
    end
  end

  // Handshake/status flags registered from the upcoming state.
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign out_state_o = data_q;

endmodule

// File: tb/tb_aespim_mixcol_engine.sv
// Bench for aespim_mixcol_engine: three instances (1, 2, 4 columns per cycle)
// checked against a GF(2^8) matrix-multiply reference model.
module tb_aespim_mixcol_engine;

  localparam int NI = 3;
  localparam int LIMIT = 20;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         in_valid  [NI];
  logic         in_inv    [NI];
  logic         out_ready [NI];
  logic         in_ready  [NI];
  logic         out_valid [NI];
  logic         busy      [NI];
  logic [127:0] in_state  [NI];
  logic [127:0] out_state [NI];

  int checks;
  int errors;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    aespim_mixcol_engine #(.COLS_PER_CYCLE(1 << g), .NUM_COLS(4)) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .clear_i     (clear),
      .in_valid_i  (in_valid[g]),
      .in_ready_o  (in_ready[g]),
      .in_inv_i    (in_inv[g]),
      .in_state_i  (in_state[g]),
      .out_valid_o (out_valid[g]),
      .out_ready_i (out_ready[g]),
      .out_state_o (out_state[g]),
      .busy_o      (busy[g])
    );
  end

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: generic GF(2^8) multiply and the MixColumns matrix as a table.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int aa;
    int p;
    aa = int'(a);
    p  = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa << 1;
      if ((aa & 'h100) != 0) aa = aa ^ 'h11B;
    end
    return 8'(p);
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0]   m [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (inv) begin m[0] = 8'd14; m[1] = 8'd11; m[2] = 8'd13; m[3] = 8'd9; end
    else     begin m[0] = 8'd2;  m[1] = 8'd3;  m[2] = 8'd1;  m[3] = 8'd1; end
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[j], s[32*c + 8*((r+j)%4) +: 8]);
        res[32*c + 8*r +: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Returns at the falling edge just after the accepting rising edge.
  task automatic start_txn(input int k, input logic [127:0] st, input logic inv);
    @(negedge clk);
    chk("in_ready_idle", 128'(in_ready[k]), 128'(1));
    in_valid[k] = 1'b1;
    in_state[k] = st;
    in_inv[k]   = inv;
    @(negedge clk);
    in_valid[k] = 1'b0;
    in_state[k] = rnd128();
    in_inv[k]   = ~inv;
    chk("busy_after_accept", 128'(busy[k]), 128'(1));
    chk("in_ready_busy", 128'(in_ready[k]), 128'(0));
  endtask

  task automatic wait_done(input int k, input logic [127:0] exp);
    int n;
    n = 0;
    while (!out_valid[k] && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_timeout", 128'(out_valid[k]), 128'(1));
    chk("latency", 128'(n), 128'(4 >> k));
    chk("result", out_state[k], exp);
  endtask

  // Hold the result under backpressure while the input side is toggled, then release.
  task automatic finish_txn(input int k, input int hold);
    logic [127:0] held;
    held = out_state[k];
    for (int i = 0; i < hold; i++) begin
      in_valid[k] = 1'($urandom);
      in_state[k] = rnd128();
      in_inv[k]   = 1'($urandom);
      @(negedge clk);
      chk("hold_valid", 128'(out_valid[k]), 128'(1));
      chk("hold_ready", 128'(in_ready[k]), 128'(0));
      chk("hold_state", out_state[k], held);
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    chk("release_valid", 128'(out_valid[k]), 128'(0));
    chk("release_ready", 128'(in_ready[k]), 128'(1));
    chk("release_busy", 128'(busy[k]), 128'(0));
  endtask

  task automatic run_txn(input int k, input logic [127:0] st, input logic inv,
                         input logic [127:0] exp, input int hold);
    start_txn(k, st, inv);
    wait_done(k, exp);
    finish_txn(k, hold);
  endtask

  task automatic chk_reset_outputs(input int k);
    chk("rst_in_ready", 128'(in_ready[k]), 128'(1));
    chk("rst_out_valid", 128'(out_valid[k]), 128'(0));
    chk("rst_out_state", out_state[k], 128'(0));
    chk("rst_busy", 128'(busy[k]), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] st;
    logic [127:0] mixed_in;
    logic [127:0] mixed_out;
    logic         inv;
    checks = 0;
    errors = 0;
    clk    = 1'b0;
    rst_n  = 1'b0;
    clear  = 1'b0;
    for (int k = 0; k < NI; k++) begin
      in_valid[k]  = 1'b0;
      in_inv[k]    = 1'b0;
      out_ready[k] = 1'b0;
      in_state[k]  = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) chk_reset_outputs(k);
    rst_n = 1'b1;

    // Known-answer vectors, one column per cycle.
    run_txn(0, {4{32'h455313DB}}, 1'b0, {4{32'hBCA14D8E}}, 0);
    run_txn(0, {4{32'hBCA14D8E}}, 1'b1, {4{32'h455313DB}}, 0);
    run_txn(0, {4{32'h4C31262D}}, 1'b0, {4{32'hF8BD7E4D}}, 0);
    run_txn(0, {4{32'hF8BD7E4D}}, 1'b1, {4{32'h4C31262D}}, 0);

    // Mixed columns on the wider instances, forward and back.
    mixed_in  = {32'h4C31262D, 32'hD5D4D4D4, 32'hC6C6C6C6, 32'h01010101};
    mixed_out = {32'hF8BD7E4D, 32'hD6D7D5D5, 32'hC6C6C6C6, 32'h01010101};
    for (int k = 0; k < NI; k++) begin
      run_txn(k, mixed_in, 1'b0, mixed_out, 0);
      run_txn(k, mixed_out, 1'b1, mixed_in, 0);
    end

    // Backpressure for 10 cycles in DONE, then an immediate follow-up transaction.
    st = rnd128();
    run_txn(0, st, 1'b0, ref_mix(st, 1'b0), 10);
    st = rnd128();
    run_txn(0, st, 1'b1, ref_mix(st, 1'b1), 0);

    // Abort in the second BUSY cycle with in_valid high.
    start_txn(0, rnd128(), 1'b0);
    @(negedge clk);
    clear       = 1'b1;
    in_valid[0] = 1'b1;
    in_state[0] = rnd128();
    @(negedge clk);
    clear       = 1'b0;
    in_valid[0] = 1'b0;
    chk_reset_outputs(0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("clear_no_valid", 128'(out_valid[0]), 128'(0));
      chk("clear_no_accept", 128'(in_ready[0]), 128'(1));
    end

    // Asynchronous reset mid-BUSY, then a full transaction.
    start_txn(0, rnd128(), 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs(0);
    #1 rst_n = 1'b1;
    st = rnd128();
    run_txn(0, st, 1'b0, ref_mix(st, 1'b0), 0);

    // Asynchronous reset while holding a result in DONE.
    st = rnd128();
    start_txn(0, st, 1'b1);
    wait_done(0, ref_mix(st, 1'b1));
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs(0);
    #1 rst_n = 1'b1;
    st = rnd128();
    run_txn(0, st, 1'b1, ref_mix(st, 1'b1), 0);

    // Random states and directions on every instance.
    for (int k = 0; k < NI; k++) begin
      for (int t = 0; t < 15; t++) begin
        st  = rnd128();
        inv = 1'($urandom);
        run_txn(k, st, inv, ref_mix(st, inv), int'($urandom_range(0, 3)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
